// File: rtl/parking_occupancy_counter_pkg.sv
// Shared definitions for the car-park occupancy counter: default sizing,
// barrier FSM state encoding and a counter-width helper.
package parking_occupancy_counter_pkg;

    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_CAPACITY    = 200;
    localparam int DEFAULT_GATE_CYCLES = 16;

    typedef enum logic {
        GATE_IDLE = 1'b0,
        GATE_OPEN = 1'b1
    } gate_state_t;

    function automatic int count_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/parking_occupancy_counter_gate_timer.sv
// Barrier timer: a start pulse holds gate_open high for exactly GATE_CYCLES
// cycles, beginning the cycle after start.
module parking_occupancy_counter_gate_timer
    import parking_occupancy_counter_pkg::*;
#(
    parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic gate_open
);

    localparam int CW = count_width(GATE_CYCLES);

    gate_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= GATE_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter holds the number of open cycles still to show, including the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            GATE_IDLE: begin
                if (start) begin
                    state_d = GATE_OPEN;
                    cnt_d   = CW'(GATE_CYCLES);
                end
            end
            GATE_OPEN: begin
                if (cnt_q == CW'(1)) begin
                    state_d = GATE_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase
    end

    assign gate_open = (state_q == GATE_OPEN);

endmodule

// File: rtl/parking_occupancy_counter.sv
// Car-park occupancy counter: edge-detects entry/exit sensors, accepts or refuses
// each vehicle, tracks occupied/free spaces and drives the two barrier timers.
module parking_occupancy_counter
    import parking_occupancy_counter_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int CAPACITY    = DEFAULT_CAPACITY,
    parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             entry_req,
    input  logic             exit_req,
    output logic [WIDTH-1:0] occupied,
    output logic [WIDTH-1:0] free,
    output logic             full,
    output logic             empty,
    output logic             entry_gate_open,
    output logic             exit_gate_open,
    output logic             entry_reject,
    output logic             exit_error
);

    localparam logic [WIDTH-1:0] CAP = WIDTH'(CAPACITY);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             entry_hist_q, entry_hist_d;
    logic             exit_hist_q, exit_hist_d;
    logic [WIDTH-1:0] occupied_q, occupied_d;
    logic [WIDTH-1:0] free_q, free_d;
    logic             entry_reject_q, entry_reject_d;
    logic             exit_error_q, exit_error_d;
    logic             is_full, is_empty;
    logic             entry_evt, exit_evt;
    logic             entry_acc, exit_acc;

    // History resets to 1 so a sensor already high when reset releases is not seen as an arrival.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_hist_q   <= 1'b1;
            exit_hist_q    <= 1'b1;
            occupied_q     <= '0;
            free_q         <= CAP;
            entry_reject_q <= 1'b0;
            exit_error_q   <= 1'b0;
        end else begin
            entry_hist_q   <= entry_hist_d;
            exit_hist_q    <= exit_hist_d;
            occupied_q     <= occupied_d;
            free_q         <= free_d;
            entry_reject_q <= entry_reject_d;
            exit_error_q   <= exit_error_d;
        end
    end

    always_comb begin
        entry_hist_d = entry_req;
        exit_hist_d  = exit_req;
        is_full      = (occupied_q == CAP);
        is_empty     = (occupied_q == '0);

        // A sensor edge while its own barrier is still up belongs to the vehicle already passing.
        entry_evt = entry_req & ~entry_hist_q & ~entry_gate_open;
        exit_evt  = exit_req & ~exit_hist_q & ~exit_gate_open;
        entry_acc = entry_evt & ~is_full;
        exit_acc  = exit_evt & ~is_empty;

        entry_reject_d = entry_evt & is_full;
        exit_error_d   = exit_evt & is_empty;

        occupied_d = occupied_q;
        if (entry_acc && !exit_acc) begin
            occupied_d = occupied_q + ONE;
        end else if (exit_acc && !entry_acc) begin
            occupied_d = occupied_q - ONE;
        end
        free_d = CAP - occupied_d;
    end

    parking_occupancy_counter_gate_timer #(.GATE_CYCLES(GATE_CYCLES)) u_entry_gate (
        .clk       (clk),
        .rst       (rst),
        .start     (entry_acc),
        .gate_open (entry_gate_open)
    );

    parking_occupancy_counter_gate_timer #(.GATE_CYCLES(GATE_CYCLES)) u_exit_gate (
        .clk       (clk),
        .rst       (rst),
        .start     (exit_acc),
        .gate_open (exit_gate_open)
    );

    assign occupied     = occupied_q;
    assign free         = free_q;
    assign full         = is_full;
    assign empty        = is_empty;
    assign entry_reject = entry_reject_q;
    assign exit_error   = exit_error_q;

endmodule
